// File: rtl/dec38_sweep.sv
// Sequential 3-to-8 decoder: one-hot LED bar plus active-low 7-segment digit for a 3-bit code.
// Latency: button press -> code register in 2 edges after first sample -> LD/SEG one edge later.
// Backpressure: none; free-running board I/O, all outputs registered and updated every edge.
module dec38_sweep #(
    parameter int DIV = 4,
    parameter int CW  = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] SW,
    input  logic       EN,
    input  logic       MODE,
    input  logic       BTN,
    output logic [7:0] LD,
    output logic [6:0] SEG,
    output logic       WRAP
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SWEEP  = 2'd2
    } state_t;

    // Terminal prescaler count; the code steps when the prescaler sits here.
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

    state_t        state;
    state_t        state_nxt;

    // Synchronizer chains: *_m is the metastability flop, *_s the usable copy.
    logic          en_m;
    logic          en_s;
    logic          mode_m;
    logic          mode_s;
    logic          btn_m;
    logic          btn_s;
    logic          btn_d;
    logic          btn_rise;

    // Decoded state qualifiers.
    logic          disp_on;
    logic          load_ok;
    logic          sweep_on;

    logic [2:0]    code_q;
    logic [CW-1:0] presc;
    logic          step;
    logic          wrap_q;

    // Active-low segment pattern (bit0 = a ... bit6 = g) for a 3-bit code.
    function automatic logic [6:0] seg_of(input logic [2:0] c);
        logic [6:0] s;
        case (c)
            3'd0:    s = 7'h40;
            3'd1:    s = 7'h79;
            3'd2:    s = 7'h24;
            3'd3:    s = 7'h30;
            3'd4:    s = 7'h19;
            3'd5:    s = 7'h12;
            3'd6:    s = 7'h02;
            default: s = 7'h78;
        endcase
        return s;
    endfunction

    // Two-flop synchronizers for the switches; the button gets a third flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_m   <= 1'b0;
            en_s   <= 1'b0;
            mode_m <= 1'b0;
            mode_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            btn_d  <= 1'b0;
        end else begin
            en_m   <= EN;
            en_s   <= en_m;
            mode_m <= MODE;
            mode_s <= mode_m;
            btn_m  <= BTN;
            btn_s  <= btn_m;
            btn_d  <= btn_s;
        end
    end

    // One pulse per press; a held button produces nothing further.
    assign btn_rise = btn_s & ~btn_d;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a low enable beats everything, then mode picks manual or sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en_s) begin
                    state_nxt = mode_s ? SWEEP : MANUAL;
                end
            end
            MANUAL: begin
                if (!en_s) begin
                    state_nxt = IDLE;
                end else if (mode_s) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (!en_s) begin
                    state_nxt = IDLE;
                end else if (!mode_s) begin
                    state_nxt = MANUAL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: what each state allows (display, button loads, automatic stepping).
    always_comb begin
        disp_on  = 1'b0;
        load_ok  = 1'b0;
        sweep_on = 1'b0;
        case (state)
            IDLE: begin
                load_ok = 1'b1;
            end
            MANUAL: begin
                disp_on = 1'b1;
                load_ok = 1'b1;
            end
            SWEEP: begin
                disp_on  = 1'b1;
                sweep_on = 1'b1;
            end
            default: begin
                disp_on  = 1'b0;
            end
        endcase
    end

    assign step = sweep_on && (presc == PRESC_LAST);

    // Prescaler: held at zero outside sweep, so every sweep entry starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!sweep_on || step) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Code register: sweep steps modulo 8; button loads only outside sweep (stored silently in idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= 3'd0;
        end else if (step) begin
            code_q <= code_q + 3'd1;
        end else if (btn_rise && load_ok) begin
            code_q <= SW;
        end
    end

    // Wrap flag marks the step that rolled 7 -> 0; a manual load of 0 never sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step && (code_q == 3'd7);
        end
    end

    // Output register: WRAP is staged alongside LD/SEG so the pulse coincides with the 0 display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LD   <= 8'h00;
            SEG  <= 7'h7F;
            WRAP <= 1'b0;
        end else begin
            LD   <= disp_on ? (8'd1 << code_q) : 8'h00;
            SEG  <= disp_on ? seg_of(code_q) : 7'h7F;
            WRAP <= wrap_q;
        end
    end

endmodule

// File: doc/dec38_sweep.md
Name: dec38_sweep

Overview:
Sequential 3-to-8 decoder with display. It takes a 3-bit code from the switches and drives a one-hot 8-LED bar plus an active-low 7-segment digit showing that code. It has two modes. In manual mode, a code is loaded on a button press. In sweep mode, a prescaled counter steps the code 0..7 automatically. On the board it is the counterpart to the 8-to-3 priority encoder: it decodes a 3-bit index back into a one-hot LED position.

Parameters:
DIV, 4, sweep prescaler period in clk cycles per code step; legal range 1..2^CW-1.
CW, 26, prescaler counter width.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
SW  input  3  code to load; static switch, sampled only on a load event.
EN  input  1  enable switch; asynchronous.
MODE  input  1  0 = manual, 1 = sweep; asynchronous.
BTN  input  1  load button, active-high; asynchronous.
LD  output  8  one-hot decode of the current code, registered.
SEG  output  7  active-low 7-seg for the current code; bit0 = a … bit6 = g; registered.
WRAP  output  1  one-cycle pulse when a sweep steps 7->0; registered.

Behaviour:
- Reset (rst_n = 0, asynchronous, takes effect immediately):
  - state = IDLE, code_q = 0, prescaler = 0, all synchronizers = 0.
  - Outputs: LD = 8'h00, SEG = 7'h7F (blank), WRAP = 0.
  - Reset asserted mid-sweep or mid-press discards all progress.
  - After release, the first transition happens only once the synchronized EN is seen.
- Synchronizers:
  - EN, MODE and BTN each pass through a 2-flop synchronizer.
  - btn_rise = sync2 & ~sync3 (a third flop), giving one pulse per press. Holding BTN high produces no further pulses.
- States: IDLE, MANUAL, SWEEP. Priority: en_s = 0 wins over everything else.
  - IDLE: if en_s = 1, go to SWEEP when mode_s = 1, otherwise MANUAL.
  - MANUAL: en_s = 0 -> IDLE; mode_s = 1 -> SWEEP.
  - SWEEP: en_s = 0 -> IDLE; mode_s = 0 -> MANUAL. code_q is kept on both exits.
- Load:
  - btn_rise in IDLE or MANUAL sets code_q <= SW on the same edge as the pulse. In IDLE the value is stored but not displayed.
  - btn_rise in SWEEP is ignored.
  - Latency: BTN first sampled high at edge k -> code_q updated at edge k+2 -> LD/SEG updated at edge k+3.
- Prescaler:
  - Cleared to 0 on every entry to SWEEP; held at 0 outside SWEEP.
  - In SWEEP it counts 0..DIV-1. At DIV-1 it returns to 0 and code_q <= code_q+1 (mod 8).
  - With DIV = 1 the code steps every cycle.
  - The first step occurs DIV cycles after SWEEP entry.
- WRAP: registered, asserted for exactly one cycle after the step in which code_q goes 7->0. It is never asserted by a manual load of 0.
- Output register, updated every edge:
  - IDLE: LD = 0, SEG = 7F.
  - MANUAL or SWEEP: LD = 1 << code_q; SEG from the table below.
- SEG table, code -> SEG: 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78 (hex).
- Invariant: LD has at most one bit set at any time.

Test Plan:
- Reset: rst_n = 0 mid-sweep with code 5 -> LD = 00, SEG = 7F, WRAP = 0 immediately, without waiting for a clk edge.
- Manual load: EN = 1, MODE = 0, SW = 3, press BTN for 10 cycles -> LD = 08, SEG = 30 three edges after the first sampled high. Change SW to 6 while still holding -> no change.
- Full manual sweep: load codes 0..7 in turn -> LD walks 01,02,…,80 and SEG matches the table for each.
- Auto sweep, DIV = 4:
  - from code 6, set MODE = 1 -> code 7 after 4 cycles, then 0;
  - WRAP high exactly one cycle, LD = 01;
  - BTN presses during the sweep are ignored.
- Mode and enable interplay:
  - in SWEEP, set MODE = 0 -> code frozen and MANUAL accepts loads;
  - EN = 0 -> blank display; load SW = 2 in IDLE, then EN = 1 -> LD = 04;
  - EN = 0 and MODE = 1 together -> IDLE.
- DIV = 1 -> code increments every cycle; WRAP pulses once every 8 cycles.
